// File: rtl/dcache_pkg.sv
// Shared definitions for the write-through data cache.
//   state_t        : controller states, also exported on the debug port
//   INDEX_BITS     : set-index width for the default geometry
//   TAG_BITS       : tag width for the default geometry
//   byte_merge()   : replace one byte lane of a 32-bit word
package dcache_pkg;

  localparam int DEF_ADDRESS_WIDTH = 32;
  localparam int DEF_SETS          = 16;
  localparam int INDEX_BITS        = $clog2(DEF_SETS);
  localparam int TAG_BITS          = DEF_ADDRESS_WIDTH - 2 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    WRITE  = 2'd2,
    BYPASS = 2'd3
  } state_t;

  // Little-endian lane insert: offset 0 is bits [7:0].
  function automatic logic [31:0] byte_merge(input logic [31:0] word,
                                             input logic [7:0]  b,
                                             input logic [1:0]  offset);
    logic [31:0] r;
    r = word;
    r[{offset, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/dcache_wt_if.sv
// CPU-side and memory-side signal bundle of the data cache.
//   slave  : the cache (takes CPU requests, drives the memory port)
//   master : the environment (CPU driver plus memory model)
// Handshake: the CPU raises cpu_req with a stable command; while cpu_stall=1
// the command must stay unchanged. A cycle with cpu_req=1 and cpu_stall=0
// completes the access (load data is valid on cpu_rd in that cycle).
// Memory port: mem_rd is a combinational read of mem_a; a write happens at the
// clock edge while mem_we=1. mem_addr_mode 1 = byte, 0 = word.
interface dcache_wt_if #(parameter int AW = 32);
  logic          cpu_req;
  logic          cpu_we;
  logic          cpu_addr_mode;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wd;
  logic [31:0]   cpu_rd;
  logic          cpu_stall;
  logic          mem_we;
  logic          mem_addr_mode;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr_mode, cpu_addr, cpu_wd,
    output cpu_rd, cpu_stall,
    output mem_we, mem_addr_mode, mem_a, mem_wd,
    input  mem_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr_mode, cpu_addr, cpu_wd,
    input  cpu_rd, cpu_stall,
    input  mem_we, mem_addr_mode, mem_a, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays of the direct-mapped cache, one 32-bit word per line.
//   lk_*  : combinational lookup (hit, line data) at lk_idx_i
//   wr_*  : single write port: tag+data+valid written at wr_idx_i
//   clr_* : conditional clear of a second line (only if valid and tag matches);
//           a misaligned word store touches two adjacent lines in one cycle
// Valid bits clear asynchronously on reset; tag/data are not reset.
module dcache_line_store #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] lk_idx_i,
  input  logic [TAG_W-1:0] lk_tag_i,
  output logic             lk_hit_o,
  output logic [31:0]      lk_data_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [31:0]      wr_data_i,
  input  logic             wr_valid_i,
  input  logic             clr_en_i,
  input  logic [IDX_W-1:0] clr_idx_i,
  input  logic [TAG_W-1:0] clr_tag_i
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  assign lk_hit_o  = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
  assign lk_data_o = data_q[lk_idx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (wr_en_i) valid_q[wr_idx_i] <= wr_valid_i;
      if (clr_en_i && valid_q[clr_idx_i] && (tag_q[clr_idx_i] == clr_tag_i))
        valid_q[clr_idx_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : CPU request port and data-memory port (dcache_wt_if.slave)
//   hit_count   : load hits (wraps)
//   miss_count  : load misses (wraps)
//   state_o     : controller state, for observation
// Loads hit in IDLE with zero stall; misses go through FILL (2 stall cycles
// total). Misaligned word loads bypass the cache. Every store takes one stall
// cycle and then writes memory in WRITE, updating or invalidating lines.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int SETS          = DEF_SETS
) (
  input  logic        clk,
  input  logic        rst_n,
  dcache_wt_if.slave  bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output state_t      state_o
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDRESS_WIDTH - 2 - IDX_W;
  localparam int WA_W  = ADDRESS_WIDTH - 2;

  state_t state_q, state_d;
  logic [31:0] hit_q, hit_d, miss_q, miss_d;
  logic hit_inc, miss_inc;

  logic [IDX_W-1:0] idx, nxt_idx;
  logic [TAG_W-1:0] tag, nxt_tag;
  logic [WA_W-1:0]  nxt_word;
  logic             aligned, lk_hit;
  logic [31:0]      lk_data;
  logic [7:0]       sel_byte;

  logic             wr_en, wr_valid, clr_en;
  logic [31:0]      wr_data;

  assign idx      = bus.cpu_addr[2+IDX_W-1:2];
  assign tag      = bus.cpu_addr[ADDRESS_WIDTH-1:2+IDX_W];
  // Second word touched by a misaligned word access.
  assign nxt_word = bus.cpu_addr[ADDRESS_WIDTH-1:2] + WA_W'(1);
  assign nxt_idx  = nxt_word[IDX_W-1:0];
  assign nxt_tag  = nxt_word[WA_W-1:IDX_W];
  assign aligned  = (bus.cpu_addr[1:0] == 2'b00);

  always_comb begin
    case (bus.cpu_addr[1:0])
      2'd0:    sel_byte = lk_data[7:0];
      2'd1:    sel_byte = lk_data[15:8];
      2'd2:    sel_byte = lk_data[23:16];
      default: sel_byte = lk_data[31:24];
    endcase
  end

  dcache_line_store #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_lines (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_idx_i   (idx),
    .lk_tag_i   (tag),
    .lk_hit_o   (lk_hit),
    .lk_data_o  (lk_data),
    .wr_en_i    (wr_en),
    .wr_idx_i   (idx),
    .wr_tag_i   (tag),
    .wr_data_i  (wr_data),
    .wr_valid_i (wr_valid),
    .clr_en_i   (clr_en),
    .clr_idx_i  (nxt_idx),
    .clr_tag_i  (nxt_tag)
  );

  always_comb begin
    state_d           = state_q;
    bus.cpu_stall     = 1'b0;
    bus.cpu_rd        = '0;
    bus.mem_we        = 1'b0;
    bus.mem_addr_mode = 1'b0;
    bus.mem_a         = bus.cpu_addr;
    bus.mem_wd        = bus.cpu_wd;
    hit_inc           = 1'b0;
    miss_inc          = 1'b0;
    wr_en             = 1'b0;
    wr_valid          = 1'b1;
    wr_data           = bus.mem_rd;
    clr_en            = 1'b0;
    // Outputs stay quiet while reset is held, whatever the CPU presents.
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_req) begin
            if (bus.cpu_we) begin
              bus.cpu_stall = 1'b1;
              state_d       = WRITE;
            end else if (bus.cpu_addr_mode || aligned) begin
              if (lk_hit) begin
                bus.cpu_rd = bus.cpu_addr_mode ? {24'h0, sel_byte} : lk_data;
                hit_inc    = 1'b1;
              end else begin
                bus.cpu_stall = 1'b1;
                state_d       = FILL;
              end
            end else begin
              bus.cpu_stall = 1'b1;
              state_d       = BYPASS;
            end
          end
        end
        FILL: begin
          bus.mem_a     = {bus.cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
          bus.cpu_stall = 1'b1;
          miss_inc      = 1'b1;
          wr_en         = 1'b1;
          state_d       = IDLE;
        end
        BYPASS: begin
          bus.cpu_rd = bus.mem_rd;
          state_d    = IDLE;
        end
        WRITE: begin
          bus.mem_we        = 1'b1;
          bus.mem_addr_mode = bus.cpu_addr_mode;
          state_d           = IDLE;
          if (bus.cpu_addr_mode) begin
            wr_en   = lk_hit;
            wr_data = byte_merge(lk_data, bus.cpu_wd[7:0], bus.cpu_addr[1:0]);
          end else if (aligned) begin
            wr_en   = lk_hit;
            wr_data = bus.cpu_wd;
          end else begin
            // Straddling store: drop both lines rather than merge two halves.
            wr_en    = lk_hit;
            wr_valid = 1'b0;
            clr_en   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign hit_d  = hit_q + 32'(hit_inc);
  assign miss_d = miss_q + 32'(miss_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: byte-addressed little-endian memory model,
// one task per scenario, inline checks, single summary line.
module tb_dcache_wt;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_wt_if #(.AW(32)) bus ();
  logic [31:0] hit_count, miss_count;
  state_t      state;

  dcache_wt #(.ADDRESS_WIDTH(32), .SETS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .state_o    (state)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Memory model: combinational read, write at clock edge.
  logic [7:0]  mem [0:4095];
  logic [11:0] ma;
  assign ma = bus.mem_a[11:0];

  always_comb begin
    if (bus.mem_addr_mode) bus.mem_rd = {24'h0, mem[ma]};
    else bus.mem_rd = {mem[ma+12'd3], mem[ma+12'd2], mem[ma+12'd1], mem[ma]};
  end

  always @(posedge clk) begin
    if (bus.mem_we) begin
      if (bus.mem_addr_mode) mem[ma] <= bus.mem_wd[7:0];
      else begin
        mem[ma]       <= bus.mem_wd[7:0];
        mem[ma+12'd1] <= bus.mem_wd[15:8];
        mem[ma+12'd2] <= bus.mem_wd[23:16];
        mem[ma+12'd3] <= bus.mem_wd[31:24];
      end
    end
  end

  // Results of the last access.
  logic [31:0] a_rd, a_wa, a_wd;
  int          a_st;
  logic        a_ws, a_wm;

  task automatic cpu_access(input logic we, input logic bmode,
                            input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr_mode = bmode;
    bus.cpu_addr = addr; bus.cpu_wd = wd;
    a_st = 0;
    @(negedge clk);
    while (bus.cpu_stall !== 1'b0 && a_st < 8) begin
      a_st++;
      @(negedge clk);
    end
    if (bus.cpu_stall !== 1'b0) begin
      checks++; errors++;
      $display("FAIL access_timeout addr=%h stall still %b after %0d cycles", addr, bus.cpu_stall, a_st);
    end
    a_rd = bus.cpu_rd; a_ws = bus.mem_we; a_wa = bus.mem_a;
    a_wm = bus.mem_addr_mode; a_wd = bus.mem_wd;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr_mode = 0;
    bus.cpu_addr = 0; bus.cpu_wd = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.cpu_stall !== 1'b0 || bus.mem_we !== 1'b0 || bus.cpu_rd !== 32'h0) begin
      errors++; $display("FAIL reset_outputs stall=%b we=%b rd=%h expected 0 0 0", bus.cpu_stall, bus.mem_we, bus.cpu_rd); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      errors++; $display("FAIL reset_counters hit=%0d miss=%0d expected 0 0", hit_count, miss_count); end
    checks++; if (state !== IDLE || bus.cpu_stall !== 1'b0) begin
      errors++; $display("FAIL reset_state state=%0d stall=%b expected 0 0", state, bus.cpu_stall); end
  endtask

  task automatic test_load_miss();
    cpu_access(0, 0, 32'h100, 0);
    checks++; if (a_st !== 2) begin errors++; $display("FAIL miss_stalls got %0d expected 2", a_st); end
    checks++; if (a_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_data got %h expected deadbeef", a_rd); end
    checks++; if (miss_count !== 1 || hit_count !== 1) begin
      errors++; $display("FAIL miss_counts hit=%0d miss=%0d expected 1 1", hit_count, miss_count); end
  endtask

  task automatic test_byte_hit();
    cpu_access(0, 1, 32'h101, 0);
    checks++; if (a_st !== 0 || a_rd !== 32'h000000BE) begin
      errors++; $display("FAIL byte_hit stalls=%0d rd=%h expected 0 000000be", a_st, a_rd); end
    checks++; if (hit_count !== 2) begin errors++; $display("FAIL byte_hit_count got %0d expected 2", hit_count); end
  endtask

  task automatic test_byte_store();
    cpu_access(1, 1, 32'h102, 32'h55);
    checks++; if (a_st !== 1 || a_ws !== 1'b1 || a_wa !== 32'h102 || a_wm !== 1'b1 || a_wd[7:0] !== 8'h55) begin
      errors++; $display("FAIL byte_store_bus stalls=%0d we=%b a=%h mode=%b wd=%h expected 1 1 102 1 55", a_st, a_ws, a_wa, a_wm, a_wd); end
    cpu_access(0, 0, 32'h100, 0);
    checks++; if (a_st !== 0 || a_rd !== 32'hDE55BEEF) begin
      errors++; $display("FAIL byte_store_merge stalls=%0d rd=%h expected 0 de55beef", a_st, a_rd); end
    checks++; if (hit_count !== 3 || miss_count !== 1) begin
      errors++; $display("FAIL byte_store_counts hit=%0d miss=%0d expected 3 1", hit_count, miss_count); end
  endtask

  task automatic test_bypass();
    cpu_access(0, 0, 32'h101, 0);
    checks++; if (a_st !== 1 || a_rd !== 32'h11DE55BE) begin
      errors++; $display("FAIL bypass stalls=%0d rd=%h expected 1 11de55be", a_st, a_rd); end
    checks++; if (hit_count !== 3 || miss_count !== 1) begin
      errors++; $display("FAIL bypass_counts hit=%0d miss=%0d expected 3 1", hit_count, miss_count); end
  endtask

  task automatic test_conflict();
    logic [31:0] e;
    exp_q.push_back(32'hDE55BEEF); exp_q.push_back(32'hCAFEF00D); exp_q.push_back(32'hDE55BEEF);
    cpu_access(0, 0, 32'h100, 0);
    e = exp_q.pop_front();
    checks++; if (a_st !== 0 || a_rd !== e) begin
      errors++; $display("FAIL conflict_a stalls=%0d rd=%h expected 0 %h", a_st, a_rd, e); end
    cpu_access(0, 0, 32'h140, 0);
    e = exp_q.pop_front();
    checks++; if (a_st !== 2 || a_rd !== e) begin
      errors++; $display("FAIL conflict_b stalls=%0d rd=%h expected 2 %h", a_st, a_rd, e); end
    cpu_access(0, 0, 32'h100, 0);
    e = exp_q.pop_front();
    checks++; if (a_st !== 2 || a_rd !== e) begin
      errors++; $display("FAIL conflict_c stalls=%0d rd=%h expected 2 %h", a_st, a_rd, e); end
    checks++; if (miss_count !== 3 || hit_count !== 6) begin
      errors++; $display("FAIL conflict_counts hit=%0d miss=%0d expected 6 3", hit_count, miss_count); end
  endtask

  task automatic test_store_miss();
    cpu_access(1, 0, 32'h200, 32'h12345678);
    checks++; if (a_st !== 1 || a_ws !== 1'b1 || a_wa !== 32'h200 || a_wm !== 1'b0 || a_wd !== 32'h12345678) begin
      errors++; $display("FAIL store_miss_bus stalls=%0d we=%b a=%h mode=%b wd=%h expected 1 1 200 0 12345678", a_st, a_ws, a_wa, a_wm, a_wd); end
    cpu_access(0, 0, 32'h200, 0);
    checks++; if (a_st !== 2 || a_rd !== 32'h12345678) begin
      errors++; $display("FAIL store_no_alloc stalls=%0d rd=%h expected 2 12345678", a_st, a_rd); end
    checks++; if (miss_count !== 4 || hit_count !== 7) begin
      errors++; $display("FAIL store_miss_counts hit=%0d miss=%0d expected 7 4", hit_count, miss_count); end
  endtask

  task automatic test_misaligned_store();
    cpu_access(0, 0, 32'h104, 0);
    checks++; if (a_st !== 2 || a_rd !== 32'h00000011) begin
      errors++; $display("FAIL mis_pre_104 stalls=%0d rd=%h expected 2 00000011", a_st, a_rd); end
    cpu_access(0, 0, 32'h100, 0);
    checks++; if (a_st !== 2 || a_rd !== 32'hDE55BEEF) begin
      errors++; $display("FAIL mis_pre_100 stalls=%0d rd=%h expected 2 de55beef", a_st, a_rd); end
    cpu_access(1, 0, 32'h102, 32'hAABBCCDD);
    checks++; if (a_st !== 1 || a_ws !== 1'b1 || a_wa !== 32'h102 || a_wm !== 1'b0) begin
      errors++; $display("FAIL mis_store_bus stalls=%0d we=%b a=%h mode=%b expected 1 1 102 0", a_st, a_ws, a_wa, a_wm); end
    cpu_access(0, 0, 32'h104, 0);
    checks++; if (a_st !== 2 || a_rd !== 32'h0000AABB) begin
      errors++; $display("FAIL mis_inval_104 stalls=%0d rd=%h expected 2 0000aabb", a_st, a_rd); end
    cpu_access(0, 0, 32'h100, 0);
    checks++; if (a_st !== 2 || a_rd !== 32'hCCDDBEEF) begin
      errors++; $display("FAIL mis_inval_100 stalls=%0d rd=%h expected 2 ccddbeef", a_st, a_rd); end
    checks++; if (miss_count !== 8 || hit_count !== 11) begin
      errors++; $display("FAIL mis_counts hit=%0d miss=%0d expected 11 8", hit_count, miss_count); end
  endtask

  task automatic test_word_store_hit();
    cpu_access(1, 0, 32'h100, 32'h0BADF00D);
    cpu_access(0, 0, 32'h100, 0);
    checks++; if (a_st !== 0 || a_rd !== 32'h0BADF00D) begin
      errors++; $display("FAIL word_store_hit stalls=%0d rd=%h expected 0 0badf00d", a_st, a_rd); end
    checks++; if (hit_count !== 12 || miss_count !== 8) begin
      errors++; $display("FAIL word_store_counts hit=%0d miss=%0d expected 12 8", hit_count, miss_count); end
  endtask

  task automatic test_reset_fill();
    @(posedge clk); #1;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr_mode = 0; bus.cpu_addr = 32'h300;
    @(posedge clk);
    @(negedge clk);
    checks++; if (state !== FILL) begin errors++; $display("FAIL rf_in_fill state=%0d expected 1", state); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== IDLE || bus.cpu_stall !== 1'b0 || hit_count !== 0 || miss_count !== 0) begin
      errors++; $display("FAIL rf_abort state=%0d stall=%b hit=%0d miss=%0d expected 0 0 0 0", state, bus.cpu_stall, hit_count, miss_count); end
    bus.cpu_req = 0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    cpu_access(0, 0, 32'h100, 0);
    checks++; if (a_st !== 2 || a_rd !== 32'h0BADF00D || miss_count !== 1 || hit_count !== 1) begin
      errors++; $display("FAIL rf_reload stalls=%0d rd=%h miss=%0d hit=%0d expected 2 0badf00d 1 1", a_st, a_rd, miss_count, hit_count); end
  endtask

  task automatic test_reset_write();
    @(posedge clk); #1;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr_mode = 1; bus.cpu_addr = 32'h300; bus.cpu_wd = 32'h77;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rw_in_write we=%b expected 1", bus.mem_we); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_we !== 1'b0 || state !== IDLE) begin
      errors++; $display("FAIL rw_abort we=%b state=%0d expected 0 0", bus.mem_we, state); end
    bus.cpu_req = 0; bus.cpu_we = 0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    cpu_access(0, 1, 32'h300, 0);
    checks++; if (a_st !== 2 || a_rd !== 32'h00000033) begin
      errors++; $display("FAIL rw_no_write stalls=%0d rd=%h expected 2 00000033", a_st, a_rd); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'hEF; mem[12'h101] = 8'hBE; mem[12'h102] = 8'hAD; mem[12'h103] = 8'hDE;
    mem[12'h104] = 8'h11;
    mem[12'h140] = 8'h0D; mem[12'h141] = 8'hF0; mem[12'h142] = 8'hFE; mem[12'h143] = 8'hCA;
    mem[12'h300] = 8'h33;
    test_reset();
    test_load_miss();
    test_byte_hit();
    test_byte_store();
    test_bypass();
    test_conflict();
    test_store_miss();
    test_misaligned_store();
    test_word_store_hit();
    test_reset_fill();
    test_reset_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
